mmss_timer: RTL and testbench

Parametrised minutes:seconds timer that generalises the minutes counter: an internal prescaler derives a one-second tick from `clk`, and cascaded seconds (0–59) and minutes (0–`MIN_MAX`) counters count up as a stopwatch or down as a countdown. It adds start/stop/pause control, preset load, wrap-or-saturate terminal behaviour and a `done` pulse. It sits between the push-button debouncers and the display encoder of the timer datapath.

---
 rtl/mmss_timer_pkg.sv | 17 +
 rtl/mmss_timer_mod_counter.sv | 45 ++++
 rtl/mmss_timer.sv | 152 +++++++++++++++
 tb/tb_mmss_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmss_timer_pkg.sv
// Shared types and constants for the minutes:seconds timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned SEC_W   = 6;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/mmss_timer_mod_counter.sv
// Generic up/down modulo counter (0..MAX) with clear, load and a wrap carry.
module mod_counter #(
  parameter int unsigned W   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         down,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] q_q, q_d;

  // Carry flags the wrap that the enabled step is about to perform.
  assign carry = en & (down ? (q_q == '0) : (q_q == MAX_V));
  assign q     = q_q;

  // Next value: clear, then load, then compare-and-reset step.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (down) q_d = (q_q == '0)    ? MAX_V : q_q - ONE_V;
      else      q_d = (q_q == MAX_V) ? '0    : q_q + ONE_V;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/mmss_timer.sv
// Minutes:seconds stopwatch/countdown with prescaler, run control and done pulse.
module mmss_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 100_000_000,
  parameter int unsigned MIN_MAX     = 99,
  parameter int unsigned MIN_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             mode_down,
  input  logic             wrap_en,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic             running,
  output logic             done
);

  localparam int unsigned       PW        = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0]     TICK_V    = PW'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0]     PONE_V    = PW'(1);
  localparam logic [SEC_W-1:0]  SEC_MAX_V = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0]  SEC_ONE_V = SEC_W'(1);
  localparam logic [MIN_W-1:0]  MIN_MAX_V = MIN_W'(MIN_MAX);

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;

  logic [SEC_W-1:0]  sec_q, ld_sec;
  logic [MIN_W-1:0]  min_q, ld_min;
  logic              sec_carry, min_carry;
  logic              is_run, tick, load_acc, cmd_stop, cmd_start;
  logic              at_top, at_zero, at_one, hold, sec_en;

  assign is_run    = (state_q == ST_RUN);
  assign tick      = is_run & (presc_q == TICK_V);
  assign load_acc  = ~clear & load & ~is_run;
  assign cmd_stop  = ~clear & ~load & stop;
  assign cmd_start = ~clear & ~load & ~stop & start;

  assign at_top  = (min_q == MIN_MAX_V) & (sec_q == SEC_MAX_V);
  assign at_zero = (min_q == '0) & (sec_q == '0);
  assign at_one  = (min_q == '0) & (sec_q == SEC_ONE_V);

  // Saturating up-count and an exhausted countdown freeze the counters on the tick.
  assign hold   = (mode_q == MODE_DOWN) ? at_zero : (at_top & ~wrap_en);
  assign sec_en = tick & ~clear & ~hold;

  assign ld_sec = (load_sec > SEC_MAX_V) ? SEC_MAX_V : load_sec;
  assign ld_min = (load_min > MIN_MAX_V) ? MIN_MAX_V : load_min;

  mod_counter #(
    .W   (SEC_W),
    .MAX (SEC_MAX)
  ) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (load_acc),
    .load_val (ld_sec),
    .en       (sec_en),
    .down     (mode_q),
    .q        (sec_q),
    .carry    (sec_carry)
  );

  mod_counter #(
    .W   (MIN_W),
    .MAX (MIN_MAX)
  ) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (load_acc),
    .load_val (ld_min),
    .en       (sec_carry),
    .down     (mode_q),
    .q        (min_q),
    .carry    (min_carry)
  );

  // Control FSM, prescaler and terminal detection, with clear > load > stop > start.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (clear || load_acc) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (is_run) begin
      // A stop on the tick cycle still applies the tick; the prescaler then restarts at 0.
      if (tick) begin
        presc_d = '0;
        if (mode_q == MODE_DOWN) begin
          if (at_zero || at_one) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (min_carry) begin
          done_d = 1'b1;
        end else if (at_top) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end else if (!cmd_stop) begin
        presc_d = presc_q + PONE_V;
      end
      if (cmd_stop && state_d == ST_RUN) state_d = ST_PAUSED;
    end else if (cmd_start) begin
      if (state_q == ST_IDLE) begin
        if (!((mode_down == MODE_DOWN) && at_zero)) begin
          state_d = ST_RUN;
          presc_d = '0;
          mode_d  = mode_down;
        end
      end else if (state_q == ST_PAUSED) begin
        state_d = ST_RUN;
        mode_d  = mode_down;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      mode_q  <= MODE_UP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign running = is_run;
  assign done    = done_q;

endmodule

// File: tb/tb_mmss_timer.sv
// Self-checking bench for mmss_timer: total-seconds model plus directed literal checks.
module tb_mmss_timer;

  localparam int CPS = 4;
  localparam int MM  = 2;
  localparam int MW  = 3;
  localparam int TOP = MM * 60 + 59;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [MW-1:0] load_min = '0;
  logic [5:0]    load_sec = '0;
  logic          mode_down = 1'b0, wrap_en = 1'b0;
  logic [MW-1:0] minutes;
  logic [5:0]    seconds;
  logic          running, done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state: total elapsed/remaining seconds, run phase within the second
  int m_t = 0, m_st = M_IDLE, m_ph = 0;
  bit m_down = 1'b0, m_done = 1'b0;

  mmss_timer #(
    .CLK_PER_SEC (CPS),
    .MIN_MAX     (MM),
    .MIN_W       (MW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .load      (load),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .mode_down (mode_down),
    .wrap_en   (wrap_en),
    .minutes   (minutes),
    .seconds   (seconds),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_time(input string nm, input int mn, input int sc);
    chk({nm, "_min"}, int'(minutes), mn);
    chk({nm, "_sec"}, int'(seconds), sc);
  endtask

  // Behavioural model on total seconds.
  always @(posedge clk or negedge rst_n) begin
    int t, st, ph, lm, ls;
    bit dn, dd, run, pz;
    if (!rst_n) begin
      m_t <= 0; m_st <= M_IDLE; m_ph <= 0; m_down <= 1'b0; m_done <= 1'b0;
    end else begin
      t = m_t; st = m_st; ph = m_ph; dn = m_down; dd = 1'b0; run = 1'b0; pz = 1'b0;
      lm = (int'(load_min) > MM) ? MM : int'(load_min);
      ls = (int'(load_sec) > 59) ? 59 : int'(load_sec);
      if (clear) begin
        st = M_IDLE; t = 0; ph = 0;
      end else if (load) begin
        if (st != M_RUN) begin t = lm * 60 + ls; ph = 0; st = M_IDLE; end
        else run = 1'b1;
      end else if (stop) begin
        run = (st == M_RUN); pz = 1'b1;
      end else if (start) begin
        if (st == M_IDLE) begin
          if (!(mode_down && t == 0)) begin st = M_RUN; ph = 0; dn = mode_down; end
        end else if (st == M_PAUSED) begin
          st = M_RUN; dn = mode_down;
        end else if (st == M_RUN) begin
          run = 1'b1;
        end
      end else begin
        run = (st == M_RUN);
      end
      if (run) begin
        if (ph == CPS - 1) begin
          ph = 0;
          if (!dn) begin
            if (t == TOP) begin
              dd = 1'b1;
              if (wrap_en) t = 0;
              else st = M_DONE;
            end else t++;
          end else begin
            if (t <= 1) begin dd = 1'b1; t = 0; st = M_DONE; end
            else t--;
          end
        end else if (!pz) begin
          ph++;
        end
        if (pz && st == M_RUN) st = M_PAUSED;
      end
      m_t <= t; m_st <= st; m_ph <= ph; m_down <= dn; m_done <= dd;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_min", int'(minutes), m_t / 60);
      chk("model_sec", int'(seconds), m_t % 60);
      chk("model_running", int'(running), int'(m_st == M_RUN));
      chk("model_done", int'(done), int'(m_done));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(2);
    chk_en = 1'b1;
    chk_time("rst", 0, 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    step(1);

    // up count from reset
    start = 1'b1; step(1); start = 1'b0;
    chk("up_running", int'(running), 1);
    step(3); chk_time("up_pre_tick", 0, 0);
    step(1); chk_time("up_first_tick", 0, 1);
    step(235); chk_time("up_0_59", 0, 59);
    step(1); chk_time("up_1_00", 1, 0);
    chk("up_running_1_00", int'(running), 1);

    // up terminal, saturate
    clear = 1'b1; step(1); clear = 1'b0;
    load = 1'b1; load_min = 3'd2; load_sec = 6'd58; wrap_en = 1'b0; step(1); load = 1'b0;
    chk_time("sat_load", 2, 58);
    start = 1'b1; step(1); start = 1'b0;
    step(4); chk_time("sat_2_59", 2, 59);
    step(4); chk_time("sat_hold", 2, 59);
    chk("sat_done", int'(done), 1);
    chk("sat_running", int'(running), 0);
    step(1); chk("sat_done_pulse_end", int'(done), 0);
    start = 1'b1; step(1); start = 1'b0;
    step(5); chk("sat_start_ignored", int'(running), 0);
    chk_time("sat_still", 2, 59);

    // up terminal, wrap (load accepted from DONE)
    load = 1'b1; load_min = 3'd2; load_sec = 6'd58; wrap_en = 1'b1; step(1); load = 1'b0;
    chk("wrap_load_idle", int'(running), 0);
    start = 1'b1; step(1); start = 1'b0;
    step(4); chk_time("wrap_2_59", 2, 59);
    step(4); chk_time("wrap_0_00", 0, 0);
    chk("wrap_done", int'(done), 1);
    chk("wrap_running", int'(running), 1);
    step(4); chk_time("wrap_0_01", 0, 1);
    chk("wrap_done_low", int'(done), 0);

    // clear and start together: clear wins
    clear = 1'b1; start = 1'b1; step(1); clear = 1'b0; start = 1'b0;
    chk_time("clr_start", 0, 0);
    chk("clr_start_running", int'(running), 0);

    // countdown start at 00:00 is ignored
    mode_down = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    chk("down_zero_ignored", int'(running), 0);

    // countdown
    load = 1'b1; load_min = 3'd1; load_sec = 6'd0; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(4); chk_time("down_0_59", 0, 59);
    step(232); chk_time("down_0_01", 0, 1);
    step(4); chk_time("down_0_00", 0, 0);
    chk("down_done", int'(done), 1);
    chk("down_running", int'(running), 0);
    mode_down = 1'b0;

    // pause keeps tick phase
    clear = 1'b1; step(1); clear = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("pause_running", int'(running), 0);
    step(10); chk_time("pause_hold", 0, 0);
    start = 1'b1; step(1); start = 1'b0;
    chk("resume_running", int'(running), 1);
    step(1); chk_time("resume_pre", 0, 0);
    step(1); chk_time("resume_tick", 0, 1);

    // stop on the tick cycle: tick applied, then full second on resume
    step(3);
    stop = 1'b1; step(1); stop = 1'b0;
    chk_time("stop_tick", 0, 2);
    chk("stop_tick_running", int'(running), 0);
    start = 1'b1; step(1); start = 1'b0;
    step(3); chk_time("stop_tick_pre", 0, 2);
    step(1); chk_time("stop_tick_next", 0, 3);

    // load ignored in RUN
    load = 1'b1; load_min = 3'd1; load_sec = 6'd10; step(1); load = 1'b0;
    chk_time("load_in_run", 0, 3);
    chk("load_in_run_running", int'(running), 1);

    // clamp
    clear = 1'b1; step(1); clear = 1'b0;
    load = 1'b1; load_min = 3'd5; load_sec = 6'd63; step(1); load = 1'b0;
    chk_time("clamp", 2, 59);

    // asynchronous reset mid-run, then first edge behaves as IDLE
    clear = 1'b1; step(1); clear = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(6);
    #2 rst_n = 1'b0;
    #1;
    chk_time("async_rst", 0, 0);
    chk("async_rst_running", int'(running), 0);
    step(2);
    rst_n = 1'b1; start = 1'b1; step(1); start = 1'b0;
    chk("post_rst_start", int'(running), 1);
    step(4); chk_time("post_rst_tick", 0, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
